// File: rtl/serial_tx_pkg.sv
// ============================================================================
// Module      : serial_tx_pkg
// Description : Shared types and helpers for the serial frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_tx_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One extra bit keeps the counter well-formed even when LENGTH/2 == 1.
  function automatic int slice_cnt_width(input int length);
    return $clog2(length / 2) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_tx_lane_shifter.sv
// ============================================================================
// Module      : serial_tx_lane_shifter
// Description : One lane's load/shift register, emitting 2 bits LSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_tx_lane_shifter
  import serial_tx_pkg::*;
#(
  parameter int LENGTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [LENGTH-1:0]  load_word,
  input  logic               shift,
  output logic [SLICE_W-1:0] slice
);

  logic [LENGTH-1:0] r_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= '0;
    end else if (load) begin
      r_word <= load_word;
    end else if (shift) begin
      r_word <= r_word >> SLICE_W;
    end
  end

  assign slice = r_word[SLICE_W-1:0];

endmodule

`default_nettype wire

// File: rtl/serial_frame_tx.sv
// ============================================================================
// Module      : serial_frame_tx
// Description : Frame transmitter streaming 4*SIZE lane words as 2-bit slices.
//               Optional shadow frame buffer: SERIAL_FRAME_TX_DOUBLE_BUF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int LENGTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [4*SIZE*LENGTH-1:0] load_data,
  input  logic                     hold,
  output logic                     start,
  output logic                     serial_valid,
  output logic [8*SIZE-1:0]        serial_data,
  output logic                     finish,
  output logic                     busy
);

  localparam int c_LANES = 4 * SIZE;
  localparam int c_CNT_W = slice_cnt_width(LENGTH);
  localparam logic [c_CNT_W-1:0] c_LAST_SLICE = c_CNT_W'(LENGTH / 2 - 1);

  state_t                       r_state;
  state_t                       w_next_state;
  logic [c_CNT_W-1:0]           r_slice_cnt;
  logic                         w_ready_raw;
  logic                         w_handshake;
  logic                         w_load_sr;
  logic                         w_shift;
  logic [c_LANES*LENGTH-1:0]    w_frame_word;
  logic [c_LANES*SLICE_W-1:0]   w_slices;

  assign w_handshake = load_valid && load_ready;
  assign w_shift     = (r_state == ST_SHIFT) && !hold;

`ifdef SERIAL_FRAME_TX_DOUBLE_BUF_EN
  logic [c_LANES*LENGTH-1:0] r_shadow;
  logic                      r_shadow_full;
  logic                      w_transfer;
  logic                      w_capture_direct;
  logic                      w_shadow_write;

  // A frame parked in the shadow is launched from DONE, or from IDLE when it
  // arrived during the DONE cycle of an otherwise empty pipeline.
  assign w_transfer       = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && r_shadow_full;
  assign w_capture_direct = (r_state == ST_IDLE) && !r_shadow_full && w_handshake;
  assign w_shadow_write   = w_handshake && !w_capture_direct;
  assign w_load_sr        = w_capture_direct || w_transfer;
  assign w_frame_word     = w_transfer ? r_shadow : load_data;
  assign w_ready_raw      = !r_shadow_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
    end else if (w_shadow_write) begin
      r_shadow      <= load_data;
      r_shadow_full <= 1'b1;
    end else if (w_transfer) begin
      r_shadow_full <= 1'b0;
    end
  end
`else
  assign w_load_sr    = w_handshake;
  assign w_frame_word = load_data;
  assign w_ready_raw  = (r_state == ST_IDLE);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_load_sr) w_next_state = ST_START;
      ST_START: w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_shift && (r_slice_cnt == c_LAST_SLICE)) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = w_load_sr ? ST_START : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slice_cnt <= '0;
    end else if (w_load_sr) begin
      r_slice_cnt <= '0;
    end else if (w_shift) begin
      r_slice_cnt <= r_slice_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < c_LANES; i++) begin : g_lanes
    serial_tx_lane_shifter #(
      .LENGTH (LENGTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (w_load_sr),
      .load_word (w_frame_word[i*LENGTH +: LENGTH]),
      .shift     (w_shift),
      .slice     (w_slices[i*SLICE_W +: SLICE_W])
    );
  end

  always_comb begin
    load_ready   = w_ready_raw && !reset;
    start        = 1'b0;
    serial_valid = 1'b0;
    finish       = 1'b0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_START: start        = 1'b1;
      ST_SHIFT: serial_valid = !hold;
      ST_DONE:  finish       = 1'b1;
      default:  ;
    endcase
    serial_data = serial_valid ? w_slices : '0;
  end

endmodule

`default_nettype wire
